set_assoc_cache: RTL and testbench



---
 rtl/set_assoc_cache.sv | 209 ++++++++++++++++++++
 tb/tb_set_assoc_cache.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_cache.sv
// N-way set-associative L1 cache with true-LRU replacement, word-serial line fill
// and write-through store handshake.
module set_assoc_cache #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int SETS   = 64,
    parameter int WAYS   = 2,
    parameter int WORDS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              flush,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_wr_ack
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 1 - OFF_W - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;
    state_t state, state_nxt;

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    assign off = addr[OFF_W:1];
    assign idx = addr[OFF_W+IDX_W:OFF_W+1];
    assign tag = addr[ADDR_W-1:OFF_W+IDX_W+1];

    logic [WAYS-1:0]   valid    [SETS];
    logic [WAY_W-1:0]  age      [SETS][WAYS];
    logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
    logic [DATA_W-1:0] data_mem [SETS][WAYS][WORDS];

    logic [WAY_W-1:0]  fill_way;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic [OFF_W-1:0]  cnt;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    logic             hit, free_found;
    logic [WAY_W-1:0] hit_way, victim;
    logic             idle_go, fill_beat, fill_last, lru_en;
    logic [IDX_W-1:0] lru_idx;
    logic [WAY_W-1:0] lru_way;
    logic [WAY_W-1:0] age_new [WAYS];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid[idx][WAY_W'(w)] && tag_mem[idx][WAY_W'(w)] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Lowest-index invalid way wins; otherwise the way whose age is WAYS-1.
    always_comb begin
        victim     = '0;
        free_found = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!free_found && !valid[idx][WAY_W'(w)]) begin
                victim     = WAY_W'(w);
                free_found = 1'b1;
            end
        end
        if (!free_found) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (age[idx][WAY_W'(w)] == WAY_W'(WAYS - 1))
                    victim = WAY_W'(w);
            end
        end
    end

    assign idle_go   = (state == IDLE) && req && !flush;
    assign fill_beat = (state == FILL) && mem_rd_valid;
    assign fill_last = fill_beat && (cnt == OFF_W'(WORDS - 1));
    assign lru_en    = (idle_go && hit) || fill_last;
    assign lru_idx   = (state == FILL) ? fill_idx : idx;
    assign lru_way   = (state == FILL) ? fill_way : hit_way;

    always_comb begin
        for (int unsigned w = 0; w < WAYS; w++) begin
            age_new[w] = age[lru_idx][WAY_W'(w)];
            if (WAY_W'(w) == lru_way)
                age_new[w] = '0;
            else if (age[lru_idx][WAY_W'(w)] < age[lru_idx][lru_way])
                age_new[w] = age[lru_idx][WAY_W'(w)] + WAY_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (idle_go) state_nxt = !hit ? FILL : (we ? WRITE : IDLE);
            FILL:    if (fill_last) state_nxt = IDLE;
            WRITE:   if (mem_wr_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready       = 1'b0;
        rdata       = '0;
        busy        = (state != IDLE);
        mem_rd_req  = 1'b0;
        mem_rd_addr = '0;
        mem_wr_req  = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        case (state)
            IDLE: begin
                if (idle_go && hit && !we) begin
                    ready = 1'b1;
                    rdata = data_mem[idx][hit_way][off];
                end
            end
            FILL: begin
                mem_rd_req  = 1'b1;
                mem_rd_addr = {fill_tag, fill_idx, cnt, 1'b0};
            end
            WRITE: begin
                mem_wr_req  = 1'b1;
                mem_wr_addr = wr_addr_q;
                mem_wr_data = wr_data_q;
                ready       = mem_wr_ack;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++)
                    age[s][w] <= WAY_W'(w);
            end
            fill_way  <= '0;
            fill_idx  <= '0;
            fill_tag  <= '0;
            cnt       <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            if (state == IDLE && flush) begin
                for (int unsigned s = 0; s < SETS; s++) begin
                    valid[s] <= '0;
                    for (int unsigned w = 0; w < WAYS; w++)
                        age[s][w] <= WAY_W'(w);
                end
            end else if (idle_go) begin
                if (!hit) begin
                    // Victim is invalidated up front so an aborted fill never leaves a stale hit.
                    fill_way             <= victim;
                    fill_idx             <= idx;
                    fill_tag             <= tag;
                    cnt                  <= '0;
                    valid[idx][victim]   <= 1'b0;
                end else if (we) begin
                    wr_addr_q <= addr;
                    wr_data_q <= wdata;
                end
            end
            if (fill_beat) begin
                cnt <= cnt + OFF_W'(1);
                if (fill_last)
                    valid[fill_idx][fill_way] <= 1'b1;
            end
            if (lru_en) begin
                for (int unsigned w = 0; w < WAYS; w++)
                    age[lru_idx][w] <= age_new[w];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_beat)
            data_mem[fill_idx][fill_way][cnt] <= mem_rd_data;
        if (fill_last)
            tag_mem[fill_idx][fill_way] <= fill_tag;
        if (idle_go && hit && we)
            data_mem[idx][hit_way][off] <= wdata;
    end
endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache: a 2-way instance with a hand-driven memory
// and a 4-way instance whose memory answers every request at once (data = address).
module tb_set_assoc_cache;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        a_req, a_we, a_flush, a_ready, a_busy;
    logic [15:0] a_addr, a_wdata, a_rdata;
    logic        a_rd_req, a_rd_valid, a_wr_req, a_wr_ack;
    logic [15:0] a_rd_addr, a_rd_data, a_wr_addr, a_wr_data;

    logic        b_req, b_we, b_flush, b_ready, b_busy;
    logic [15:0] b_addr, b_wdata, b_rdata;
    logic        b_rd_req, b_rd_valid, b_wr_req, b_wr_ack;
    logic [15:0] b_rd_addr, b_rd_data, b_wr_addr, b_wr_data;

    set_assoc_cache #(.WAYS(2)) dut_a (
        .clk(clk), .rst(rst), .req(a_req), .we(a_we), .addr(a_addr), .wdata(a_wdata),
        .flush(a_flush), .rdata(a_rdata), .ready(a_ready), .busy(a_busy),
        .mem_rd_req(a_rd_req), .mem_rd_addr(a_rd_addr), .mem_rd_valid(a_rd_valid),
        .mem_rd_data(a_rd_data), .mem_wr_req(a_wr_req), .mem_wr_addr(a_wr_addr),
        .mem_wr_data(a_wr_data), .mem_wr_ack(a_wr_ack)
    );

    set_assoc_cache #(.WAYS(4)) dut_b (
        .clk(clk), .rst(rst), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata),
        .flush(b_flush), .rdata(b_rdata), .ready(b_ready), .busy(b_busy),
        .mem_rd_req(b_rd_req), .mem_rd_addr(b_rd_addr), .mem_rd_valid(b_rd_valid),
        .mem_rd_data(b_rd_data), .mem_wr_req(b_wr_req), .mem_wr_addr(b_wr_addr),
        .mem_wr_data(b_wr_data), .mem_wr_ack(b_wr_ack)
    );

    assign b_rd_valid = b_rd_req;
    assign b_rd_data  = b_rd_addr;
    assign b_wr_ack   = b_wr_req;

    // Load on dut_a with a zero-wait memory returning data = address.
    task automatic load_a(input logic [15:0] a, output logic [15:0] data, output int cyc,
                          output int beats, output logic [15:0] first_addr);
        a_req = 1'b1; a_we = 1'b0; a_addr = a;
        cyc = 0; beats = 0; data = '0; first_addr = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a_ready) begin
                data = a_rdata;
                break;
            end
            a_rd_valid = a_rd_req;
            a_rd_data  = a_rd_addr;
            if (a_rd_req) begin
                if (beats == 0) first_addr = a_rd_addr;
                beats++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        a_req = 1'b0; a_rd_valid = 1'b0;
    endtask

    task automatic load_b(input logic [15:0] a, output logic [15:0] data, output int cyc);
        b_req = 1'b1; b_addr = a; cyc = 0; data = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (b_ready) begin
                data = b_rdata;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        b_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_req = 0; a_we = 0; a_flush = 0; a_addr = '0; a_wdata = '0;
        a_rd_valid = 0; a_rd_data = '0; a_wr_ack = 0;
        b_req = 0; b_we = 0; b_flush = 0; b_addr = '0; b_wdata = '0;
        #1;
        checks++;
        if ({a_ready, a_busy, a_rd_req, a_wr_req} !== 4'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=0000", {a_ready, a_busy, a_rd_req, a_wr_req});
        end
        checks++;
        if ({a_rdata, a_rd_addr, a_wr_addr, a_wr_data} !== 64'h0) begin
            failures++;
            $display("FAIL reset_data got=%h want=0", {a_rdata, a_rd_addr, a_wr_addr, a_wr_data});
        end
        checks++;
        if ({b_ready, b_busy, b_rd_req, b_wr_req} !== 4'b0) begin
            failures++;
            $display("FAIL reset_b got=%b want=0000", {b_ready, b_busy, b_rd_req, b_wr_req});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_read_miss();
        logic [15:0] exp_addr;
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h1234;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b0) begin
            failures++;
            $display("FAIL miss_no_ready got=%b want=0", a_ready);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            exp_addr = 16'h1230 + 16'(2 * i);
            checks++;
            if (a_rd_req !== 1'b1 || a_rd_addr !== exp_addr) begin
                failures++;
                $display("FAIL fill_addr beat=%0d got req=%b addr=%h want req=1 addr=%h",
                         i, a_rd_req, a_rd_addr, exp_addr);
            end
            a_rd_valid = 1'b1;
            a_rd_data  = exp_addr;
        end
        @(posedge clk); #1;
        a_rd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1 || a_rdata !== 16'h1234) begin
            failures++;
            $display("FAIL miss_replay got ready=%b rdata=%h want ready=1 rdata=1234", a_ready, a_rdata);
        end
        @(posedge clk); #1;
        a_req = 1'b0;
    endtask

    task automatic test_read_hit();
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h1236;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1 || a_rdata !== 16'h1236 || a_rd_req !== 1'b0) begin
            failures++;
            $display("FAIL read_hit got ready=%b rdata=%h rd_req=%b want 1/1236/0",
                     a_ready, a_rdata, a_rd_req);
        end
        @(posedge clk); #1;
        a_req = 1'b0;
        @(negedge clk);
        checks++;
        if (a_rd_req !== 1'b0 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL hit_no_fill got rd_req=%b busy=%b want 0/0", a_rd_req, a_busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lru_2way();
        logic [15:0] seq_addr [6] = '{16'h0400, 16'h0800, 16'h0400, 16'h0C00, 16'h0400, 16'h0800};
        int          seq_cyc  [6] = '{9, 9, 0, 9, 0, 9};
        logic [15:0] d, fa;
        int          c, bt;
        for (int i = 0; i < 6; i++) begin
            load_a(seq_addr[i], d, c, bt, fa);
            checks++;
            if (c !== seq_cyc[i] || d !== seq_addr[i]) begin
                failures++;
                $display("FAIL lru2 step=%0d addr=%h got cyc=%0d data=%h want cyc=%0d data=%h",
                         i, seq_addr[i], c, d, seq_cyc[i], seq_addr[i]);
            end
        end
    endtask

    task automatic test_lru_4way();
        logic [15:0] seq_addr [10] = '{16'h0400, 16'h0800, 16'h0C00, 16'h1000, 16'h0400,
                                       16'h1400, 16'h0400, 16'h0C00, 16'h1000, 16'h0800};
        int          seq_cyc  [10] = '{9, 9, 9, 9, 0, 9, 0, 0, 0, 9};
        logic [15:0] d;
        int          c;
        for (int i = 0; i < 10; i++) begin
            load_b(seq_addr[i], d, c);
            checks++;
            if (c !== seq_cyc[i] || d !== seq_addr[i]) begin
                failures++;
                $display("FAIL lru4 step=%0d addr=%h got cyc=%0d data=%h want cyc=%0d data=%h",
                         i, seq_addr[i], c, d, seq_cyc[i], seq_addr[i]);
            end
        end
    endtask

    task automatic test_write_hit();
        logic [15:0] d, fa;
        int          c, bt;
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'h1234; a_wdata = 16'hBEEF; a_wr_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b0) begin
            failures++;
            $display("FAIL store_req_cycle got ready=%b want 0", a_ready);
        end
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (a_wr_req !== 1'b1 || a_wr_addr !== 16'h1234 || a_wr_data !== 16'hBEEF || a_ready !== 1'b0) begin
                failures++;
                $display("FAIL store_wait cyc=%0d got req=%b addr=%h data=%h ready=%b want 1/1234/beef/0",
                         j, a_wr_req, a_wr_addr, a_wr_data, a_ready);
            end
        end
        @(posedge clk); #1;
        a_wr_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1 || a_wr_req !== 1'b1) begin
            failures++;
            $display("FAIL store_ack got ready=%b wr_req=%b want 1/1", a_ready, a_wr_req);
        end
        @(posedge clk); #1;
        a_wr_ack = 1'b0; a_req = 1'b0; a_we = 1'b0;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b0 || a_ready !== 1'b0 || a_wr_req !== 1'b0) begin
            failures++;
            $display("FAIL store_done got busy=%b ready=%b wr_req=%b want 0/0/0", a_busy, a_ready, a_wr_req);
        end
        @(posedge clk); #1;
        load_a(16'h1234, d, c, bt, fa);
        checks++;
        if (c !== 0 || d !== 16'hBEEF) begin
            failures++;
            $display("FAIL store_readback got cyc=%0d data=%h want cyc=0 data=beef", c, d);
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [15:0] d, fa;
        int          c, bt;
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h5678;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            a_rd_valid = 1'b1;
            a_rd_data  = 16'h5670 + 16'(2 * i);
        end
        @(posedge clk); #1;
        a_rd_valid = 1'b0;
        checks++;
        if (a_busy !== 1'b1 || a_rd_addr !== 16'h5676) begin
            failures++;
            $display("FAIL pre_reset_fill got busy=%b addr=%h want 1/5676", a_busy, a_rd_addr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({a_ready, a_busy, a_rd_req, a_wr_req} !== 4'b0 ||
            {a_rdata, a_rd_addr, a_wr_addr, a_wr_data} !== 64'h0) begin
            failures++;
            $display("FAIL async_reset got ctrl=%b data=%h want 0",
                     {a_ready, a_busy, a_rd_req, a_wr_req}, {a_rdata, a_rd_addr, a_wr_addr, a_wr_data});
        end
        @(posedge clk); #1;
        rst = 1'b0; a_req = 1'b0;
        @(posedge clk); #1;
        load_a(16'h1234, d, c, bt, fa);
        checks++;
        if (c !== 9 || bt !== 8 || fa !== 16'h1230 || d !== 16'h1234) begin
            failures++;
            $display("FAIL refill_after_reset got cyc=%0d beats=%0d first=%h data=%h want 9/8/1230/1234",
                     c, bt, fa, d);
        end
        load_a(16'h5678, d, c, bt, fa);
        checks++;
        if (c !== 9 || d !== 16'h5678) begin
            failures++;
            $display("FAIL aborted_line_invalid got cyc=%0d data=%h want 9/5678", c, d);
        end
    endtask

    task automatic test_flush();
        logic [15:0] d, fa;
        int          c, bt;
        load_a(16'h5678, d, c, bt, fa);
        checks++;
        if (c !== 0 || d !== 16'h5678) begin
            failures++;
            $display("FAIL pre_flush_hit got cyc=%0d data=%h want 0/5678", c, d);
        end
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h1234; a_flush = 1'b1;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_cycle_ready got=%b want 0", a_ready);
        end
        @(posedge clk); #1;
        a_flush = 1'b0; a_req = 1'b0;
        @(posedge clk); #1;
        load_a(16'h1234, d, c, bt, fa);
        checks++;
        if (c !== 9 || d !== 16'h1234) begin
            failures++;
            $display("FAIL post_flush_1234 got cyc=%0d data=%h want 9/1234", c, d);
        end
        load_a(16'h5678, d, c, bt, fa);
        checks++;
        if (c !== 9 || d !== 16'h5678) begin
            failures++;
            $display("FAIL post_flush_5678 got cyc=%0d data=%h want 9/5678", c, d);
        end
        load_a(16'h1236, d, c, bt, fa);
        checks++;
        if (c !== 0 || d !== 16'h1236) begin
            failures++;
            $display("FAIL post_flush_refilled got cyc=%0d data=%h want 0/1236", c, d);
        end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_read_hit();
        test_lru_2way();
        test_lru_4way();
        test_write_hit();
        test_reset_mid_fill();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
